hazard_halt_ctrl: RTL
=====================

Name: hazard_halt_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Resolves load-use stalls between ID and EX, and flushes wrong-path instructions on branches and jumps taken in EX.
- Freezes the whole pipeline when a halting syscall reaches WB, and resumes on an operator "go" edge.
- Keeps saturating performance counters (cycles, stalls, flushes) for the display logic.

Parameters:
- CNT_W, 32: width of each performance counter.
- HALT_CODE, 32'd10: value of $v0 at WB syscall that halts the core. Any other value is a non-halting syscall.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_mem_to_reg  in  1  EX instruction is a load (lw/lh).
- ex_wreg  in  5  destination register of the EX instruction.
- ex_redirect  in  1  EX resolved a taken beq/bne/bltz, or a j/jal/jr.
- wb_syscall  in  1  instruction in WB is syscall.
- wb_v0  in  32  $v0 value seen by the WB syscall.
- go  in  1  operator resume level (button, already debounced).
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to a bubble.
- idex_flush  out  1  clear ID/EX to a bubble.
- pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB registers.
- halted  out  1  core frozen (state HALT).
- cnt_cycle  out  CNT_W  executed cycles.
- cnt_stall  out  CNT_W  load-use stall cycles.
- cnt_flush  out  CNT_W  redirect flushes.

Behaviour:
- States: RUN, HALT, RESUME. Reset goes to RUN asynchronously. On reset all counters are 0 and go_q (registered go) is 0.
- Reset output values: pc_en=1, ifid_en=1, pipe_en=1, ifid_flush=0, idex_flush=0, halted=0.
- Outputs are combinational from the current state and inputs. State, go_q and counters update on the rising clk edge.
- Derived conditions:
  - lu = ex_mem_to_reg & ex_wreg!=0 & ((id_use_rs & id_rs==ex_wreg) | (id_use_rt & id_rt==ex_wreg)).
  - hd = wb_syscall & wb_v0==HALT_CODE & state==RUN.
- Priority within RUN/RESUME, highest first:
  - hd: pc_en=0, ifid_en=0, pipe_en=0, no flushes. Next state is HALT.
  - ex_redirect: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. A coincident lu is ignored (wrong path) and is not counted as a stall.
  - lu: pc_en=0, ifid_en=0, idex_flush=1, pipe_en=1. One bubble per cycle while lu holds; a load-use normally costs exactly one cycle.
  - Otherwise: all enables 1, no flushes.
- HALT:
  - pc_en=0, ifid_en=0, pipe_en=0, flushes 0, halted=1.
  - All hazard inputs are ignored.
  - A rising edge of go (go & ~go_q) moves the state to RESUME. A go held high from before HALT does not resume.
- RESUME:
  - Lasts exactly one cycle with normal RUN priority, except that hd is masked so the halting syscall can retire from WB.
  - Next state is RUN.
- Counters (all saturate at all-ones, never wrap):
  - cnt_cycle increments in every RUN/RESUME cycle, including the hd cycle. It holds during HALT.
  - cnt_stall increments in cycles where lu wins priority.
  - cnt_flush increments in cycles where ex_redirect wins priority.
- ex_wreg==0 never causes a stall. A non-halting syscall has no effect.
- rst asserted during any state returns to RUN immediately and clears the counters.

Test Plan:
- Load-use: EX lw with ex_wreg=8; ID id_rs=8, id_use_rs=1 for 1 cycle → pc_en=0, ifid_en=0, idex_flush=1 for that cycle; cnt_stall goes 0→1. Same setup with ex_wreg=0 → no stall.
- Redirect+stall: ex_redirect=1 and lu=1 in the same cycle → ifid_flush=1, idex_flush=1, pc_en=1; cnt_flush=1, cnt_stall unchanged.
- Halt/resume: wb_syscall=1, wb_v0=10 → pipe_en=0 that cycle and halted=1 next cycle. With go held 1 throughout, the core stays halted. A 0→1 go edge gives 1 RESUME cycle with pipe_en=1 and halted=0, then RUN; no re-halt while the syscall is still in WB.
- Non-halting syscall (wb_v0=1) → no state change, all enables 1.
- Counter saturation: CNT_W=4, run 20 cycles → cnt_cycle=15 and it holds. While HALT, cnt_cycle is frozen.
- Reset asserted asynchronously mid-HALT, between clock edges → halted=0, all counters 0, outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/hazard_halt_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes, halt/resume on
// syscall, and saturating performance counters.
module hazard_halt_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_redirect,
  input  logic             wb_syscall,
  input  logic [31:0]      wb_v0,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic [1:0] {RUN, HALT, RESUME} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             go_q;
  logic [CNT_W-1:0] cyc_q, stl_q, fl_q;
  logic             lu, hd;
  logic             cyc_inc, stl_inc, fl_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + ONE : v;
  endfunction

  assign lu = ex_mem_to_reg && (ex_wreg != 5'd0) &&
              ((id_use_rs && (id_rs == ex_wreg)) || (id_use_rt && (id_rt == ex_wreg)));
  // Only RUN can halt, so the syscall that caused the halt retires during RESUME.
  assign hd = wb_syscall && (wb_v0 == HALT_CODE) && (state_q == RUN);

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    pipe_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    state_d    = state_q;
    cyc_inc    = 1'b0;
    stl_inc    = 1'b0;
    fl_inc     = 1'b0;
    case (state_q)
      HALT: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        pipe_en = 1'b0;
        halted  = 1'b1;
        if (go && !go_q) state_d = RESUME;
      end
      default: begin
        cyc_inc = 1'b1;
        state_d = RUN;
        if (hd) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          pipe_en = 1'b0;
          state_d = HALT;
        end else if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          fl_inc     = 1'b1;
        end else if (lu) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          stl_inc    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      go_q    <= 1'b0;
      cyc_q   <= '0;
      stl_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
      cyc_q   <= sat_inc(cyc_q, cyc_inc);
      stl_q   <= sat_inc(stl_q, stl_inc);
      fl_q    <= sat_inc(fl_q, fl_inc);
    end
  end

  assign cnt_cycle = cyc_q;
  assign cnt_stall = stl_q;
  assign cnt_flush = fl_q;

endmodule
